// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two clients, the arbiter and the shared memory port.
interface mem_arbiter_if #(
    parameter int unsigned W = 68
);
    // client side
    logic [1:0]       cli_put_valid;
    logic [2*W-1:0]   cli_put_request;
    logic [1:0]       cli_put_ready;
    logic [1:0]       cli_get_valid;
    logic [1:0]       cli_get_ready;
    logic [W-1:0]     cli_get_response;
    // memory side
    logic             mem_put_valid;
    logic [W-1:0]     mem_put_request;
    logic             mem_put_ready;
    logic             mem_get_valid;
    logic             mem_get_ready;
    logic [W-1:0]     mem_get_response;

    // Arbiter view.
    modport slave (
        input  cli_put_valid,
        input  cli_put_request,
        output cli_put_ready,
        input  cli_get_valid,
        output cli_get_ready,
        output cli_get_response,
        output mem_put_valid,
        output mem_put_request,
        input  mem_put_ready,
        output mem_get_valid,
        input  mem_get_ready,
        input  mem_get_response
    );

    // Environment view (clients plus memory).
    modport master (
        output cli_put_valid,
        output cli_put_request,
        input  cli_put_ready,
        output cli_get_valid,
        input  cli_get_ready,
        input  cli_get_response,
        input  mem_put_valid,
        input  mem_put_request,
        output mem_put_ready,
        input  mem_get_valid,
        output mem_get_ready,
        output mem_get_response
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between two clients;
// a tag FIFO of grant ids routes each response back to its issuer.
module mem_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 68
) (
    input  logic                   CLK,
    input  logic                   RST,
    mem_arbiter_if.slave           bus,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   orphan_resp
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_q, last_d;
    logic             orphan_q, orphan_d;

    logic             can_issue;
    logic             grant;
    logic             gnt_id;
    logic             head_id;
    logic             route_ok;
    logic             pop;

    // Request arbitration: round-robin on ties, blocked when memory busy or FIFO full.
    always_comb begin
        can_issue = !RST && bus.mem_put_ready && (count_q < CW'(DEPTH));
        grant     = 1'b0;
        gnt_id    = 1'b0;
        if (can_issue) begin
            case (bus.cli_put_valid)
                2'b01:   begin grant = 1'b1; gnt_id = 1'b0;    end
                2'b10:   begin grant = 1'b1; gnt_id = 1'b1;    end
                2'b11:   begin grant = 1'b1; gnt_id = ~last_q; end
                default: begin grant = 1'b0; gnt_id = 1'b0;    end
            endcase
        end
        bus.cli_put_ready   = grant ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        bus.mem_put_valid   = grant;
        bus.mem_put_request = gnt_id ? bus.cli_put_request[W +: W]
                                     : bus.cli_put_request[0 +: W];
    end

    // Response routing to the client whose tag sits at the FIFO head.
    always_comb begin
        head_id              = tag_q[rd_ptr_q];
        route_ok             = !RST && bus.mem_get_ready && (count_q != '0);
        bus.cli_get_ready    = route_ok ? (head_id ? 2'b10 : 2'b01) : 2'b00;
        pop                  = route_ok && bus.cli_get_valid[head_id];
        bus.mem_get_valid    = pop;
        bus.cli_get_response = bus.mem_get_response;
    end

    // Next-state for tag FIFO, round-robin pointer and orphan flag.
    always_comb begin
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        orphan_d = orphan_q | (bus.mem_get_ready && (count_q == '0));
        if (grant) begin
            tag_d[wr_ptr_q] = gnt_id;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            last_d          = gnt_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({grant, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; last resets to 1 so client 0 wins the first tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b1;
            orphan_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            orphan_q <= orphan_d;
        end
    end

    // Status outputs, held at zero while reset is asserted.
    always_comb begin
        outstanding = RST ? '0 : count_q;
        orphan_resp = !RST && orphan_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 68;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [OW-1:0] outstanding;
    logic          orphan_resp;

    mem_arbiter_if #(.W(W)) bus();

    mem_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .outstanding (outstanding),
        .orphan_resp (orphan_resp)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] pv;
        logic       mpr;
        logic       mgr;
        logic [1:0] gv;
        logic [1:0] e_pr;
        logic [1:0] e_gr;
        logic       e_mgv;
        logic [2:0] e_out;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = {4'($urandom), 32'($urandom), 32'($urandom)};
        return r;
    endfunction

    task automatic idle_inputs();
        bus.cli_put_valid    = 2'b00;
        bus.cli_get_valid    = 2'b00;
        bus.mem_put_ready    = 1'b0;
        bus.mem_get_ready    = 1'b0;
        bus.cli_put_request  = '0;
        bus.mem_get_response = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold reset for two edges, release 1 time unit after a rising edge.
    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    logic [W-1:0] req0, req1, r1, r2;
    int           hq[$];
    logic         lst;
    int           mq[$];
    logic         mlast, morph;

    initial begin
        RST = 1'b1;
        idle_inputs();

        // ---------------- table-driven: fill, full, pop-while-full ----------------
        vt[0]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 3'd0};
        vt[1]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'd1};
        vt[2]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 3'd2};
        vt[3]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'd3};
        vt[4]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd4};
        vt[5]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 3'd4};
        vt[6]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 3'd3};
        vt[7]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 3'd4};
        vt[8]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b10, 2'b01, 1'b0, 3'd3};
        vt[9]  = '{2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 3'd4};
        vt[10] = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd3};

        #2;
        check("rst_put_ready", W'(bus.cli_put_ready), W'(2'b00));
        check("rst_outstanding", W'(outstanding), W'(0));
        check("rst_orphan", W'(orphan_resp), W'(0));

        do_reset();
        req0 = {4'hF, 32'h0000_0200, 32'hAAAA_0000};
        req1 = {4'h3, 32'h0000_0100, 32'hBBBB_1111};
        for (int i = 0; i < 11; i++) begin
            bus.cli_put_request = {req1, req0};
            bus.cli_put_valid   = vt[i].pv;
            bus.mem_put_ready   = vt[i].mpr;
            bus.mem_get_ready   = vt[i].mgr;
            bus.cli_get_valid   = vt[i].gv;
            #1;
            check($sformatf("vec%0d_put_ready", i), W'(bus.cli_put_ready), W'(vt[i].e_pr));
            check($sformatf("vec%0d_mem_put_valid", i), W'(bus.mem_put_valid), W'(|vt[i].e_pr));
            check($sformatf("vec%0d_get_ready", i), W'(bus.cli_get_ready), W'(vt[i].e_gr));
            check($sformatf("vec%0d_mem_get_valid", i), W'(bus.mem_get_valid), W'(vt[i].e_mgv));
            check($sformatf("vec%0d_outstanding", i), W'(outstanding), W'(vt[i].e_out));
            if (vt[i].e_pr != 2'b00)
                check($sformatf("vec%0d_mem_put_request", i), bus.mem_put_request,
                      (vt[i].e_pr == 2'b10) ? req1 : req0);
            tick();
        end

        // ---------------- routing of two responses ----------------
        do_reset();
        req1 = {4'hF, 32'h0000_0100, 32'h1111_1111};
        req0 = {4'hF, 32'h0000_0200, 32'h2222_2222};
        r1   = {4'h0, 32'h0, 32'hDEAD_0001};
        r2   = {4'h0, 32'h0, 32'hBEEF_0002};
        bus.cli_put_request = {req1, req0};
        bus.mem_put_ready   = 1'b1;
        bus.cli_put_valid   = 2'b10;
        #1;
        check("route_grant1", W'(bus.cli_put_ready), W'(2'b10));
        check("route_req1", bus.mem_put_request, req1);
        tick();
        bus.cli_put_valid = 2'b01;
        #1;
        check("route_grant0", W'(bus.cli_put_ready), W'(2'b01));
        check("route_req0", bus.mem_put_request, req0);
        tick();
        bus.cli_put_valid    = 2'b00;
        bus.mem_get_ready    = 1'b1;
        bus.mem_get_response = r1;
        bus.cli_get_valid    = 2'b00;
        #1;
        check("route_r1_ready", W'(bus.cli_get_ready), W'(2'b10));
        check("route_r1_hold", W'(bus.mem_get_valid), W'(0));
        check("route_r1_data", bus.cli_get_response, r1);
        tick();
        bus.cli_get_valid = 2'b10;
        #1;
        check("route_r1_pop", W'(bus.mem_get_valid), W'(1));
        tick();
        bus.mem_get_response = r2;
        bus.cli_get_valid    = 2'b01;
        #1;
        check("route_r2_ready", W'(bus.cli_get_ready), W'(2'b01));
        check("route_r2_pop", W'(bus.mem_get_valid), W'(1));
        check("route_r2_data", bus.cli_get_response, r2);
        check("route_out_before", W'(outstanding), W'(1));
        tick();
        bus.mem_get_ready = 1'b0;
        bus.cli_get_valid = 2'b00;
        #1;
        check("route_out_after", W'(outstanding), W'(0));
        check("route_no_orphan", W'(orphan_resp), W'(0));

        // ---------------- push and pop together at count 2, pointer wrap ----------------
        do_reset();
        bus.mem_put_ready = 1'b1;
        bus.cli_put_valid = 2'b11;
        hq = {};
        hq.push_back(0);
        tick();
        hq.push_back(1);
        tick();
        lst = 1'b1;
        bus.mem_get_ready = 1'b1;
        bus.cli_get_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("pp%0d_outstanding", i), W'(outstanding), W'(2));
            check($sformatf("pp%0d_put_ready", i), W'(bus.cli_put_ready), W'(lst ? 2'b01 : 2'b10));
            check($sformatf("pp%0d_get_ready", i), W'(bus.cli_get_ready), W'((hq[0] == 1) ? 2'b10 : 2'b01));
            check($sformatf("pp%0d_mem_get_valid", i), W'(bus.mem_get_valid), W'(1));
            void'(hq.pop_front());
            hq.push_back(lst ? 0 : 1);
            lst = ~lst;
            @(posedge CLK);
            #1;
        end

        // ---------------- orphan response ----------------
        do_reset();
        bus.mem_get_ready = 1'b1;
        bus.cli_get_valid = 2'b11;
        #1;
        check("orph_mem_get_valid", W'(bus.mem_get_valid), W'(0));
        check("orph_get_ready", W'(bus.cli_get_ready), W'(2'b00));
        check("orph_before", W'(orphan_resp), W'(0));
        tick();
        bus.mem_get_ready = 1'b0;
        bus.cli_get_valid = 2'b00;
        check("orph_set", W'(orphan_resp), W'(1));
        repeat (3) tick();
        check("orph_sticky", W'(orphan_resp), W'(1));
        RST = 1'b1;
        #1;
        check("orph_cleared", W'(orphan_resp), W'(0));

        // ---------------- asynchronous reset mid-transfer ----------------
        do_reset();
        bus.mem_put_ready = 1'b1;
        bus.cli_put_valid = 2'b11;
        repeat (3) tick();
        bus.mem_get_ready = 1'b1;
        bus.cli_get_valid = 2'b11;
        #1;
        check("ar_out3", W'(outstanding), W'(3));
        check("ar_grant1", W'(bus.cli_put_ready), W'(2'b10));
        #2;
        RST = 1'b1;
        #1;
        check("ar_put_ready", W'(bus.cli_put_ready), W'(2'b00));
        check("ar_get_ready", W'(bus.cli_get_ready), W'(2'b00));
        check("ar_mem_put_valid", W'(bus.mem_put_valid), W'(0));
        check("ar_mem_get_valid", W'(bus.mem_get_valid), W'(0));
        check("ar_outstanding", W'(outstanding), W'(0));
        check("ar_orphan", W'(orphan_resp), W'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.mem_get_ready = 1'b0;
        bus.cli_get_valid = 2'b00;
        #1;
        check("ar_out_after", W'(outstanding), W'(0));
        check("ar_first_tie", W'(bus.cli_put_ready), W'(2'b01));
        tick();

        // ---------------- randomized run against a queue-based model ----------------
        do_reset();
        mq    = {};
        mlast = 1'b1;
        morph = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic [1:0]   pv, gv, e_pr, e_gr;
            logic         mpr, mgr, e_grant, e_g, e_pop;
            logic [W-1:0] q0, q1, rsp;
            pv  = 2'($urandom);
            gv  = 2'($urandom);
            mpr = ($urandom_range(0, 3) != 0);
            mgr = ($urandom_range(0, 2) == 0);
            q0  = rand_word();
            q1  = rand_word();
            rsp = rand_word();
            bus.cli_put_valid    = pv;
            bus.cli_get_valid    = gv;
            bus.mem_put_ready    = mpr;
            bus.mem_get_ready    = mgr;
            bus.cli_put_request  = {q1, q0};
            bus.mem_get_response = rsp;
            #1;
            e_grant = 1'b0;
            e_g     = 1'b0;
            if (mpr && mq.size() < DEPTH && pv != 2'b00) begin
                e_grant = 1'b1;
                if (pv == 2'b11) e_g = (mlast == 1'b1) ? 1'b0 : 1'b1;
                else             e_g = (pv == 2'b10);
            end
            e_pr  = e_grant ? (e_g ? 2'b10 : 2'b01) : 2'b00;
            e_gr  = 2'b00;
            e_pop = 1'b0;
            if (mgr && mq.size() > 0) begin
                e_gr  = (mq[0] == 1) ? 2'b10 : 2'b01;
                e_pop = gv[mq[0]];
            end
            check("rnd_put_ready", W'(bus.cli_put_ready), W'(e_pr));
            check("rnd_mem_put_valid", W'(bus.mem_put_valid), W'(e_grant));
            if (e_grant) check("rnd_mem_put_request", bus.mem_put_request, e_g ? q1 : q0);
            check("rnd_get_ready", W'(bus.cli_get_ready), W'(e_gr));
            check("rnd_mem_get_valid", W'(bus.mem_get_valid), W'(e_pop));
            check("rnd_get_response", bus.cli_get_response, rsp);
            check("rnd_outstanding", W'(outstanding), W'(mq.size()));
            check("rnd_orphan", W'(orphan_resp), W'(morph));
            if (mgr && mq.size() == 0) morph = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_grant) begin
                mq.push_back(e_g ? 1 : 0);
                mlast = e_g;
            end
            @(posedge CLK);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
